pu_feeder: RTL and testbench

Upstream feeder for the 4-tap processing unit. It loads four 5-bit weights serially and accepts a 5-bit activation stream through a valid/ready handshake. It keeps a stride-1 sliding window of the four most recent activations in the current row. It drives the processing unit's `A1..A4`, `W1..W4` and `enReg` inputs, plus a result-valid strobe aligned with the processing unit's registered output.

---
 rtl/pu_feeder_pkg.sv | 18 +
 rtl/pu_feeder_window_shift4.sv | 48 ++++
 rtl/pu_feeder.sv | 158 +++++++++++++++
 tb/tb_pu_feeder.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pu_feeder_pkg.sv
// Shared constants, state type and sizing helper for the processing-unit feeder.
package pu_feeder_pkg;

    localparam int DW_DEF      = 5;
    localparam int ROW_LEN_DEF = 16;
    localparam int COL_W_DEF   = $clog2(ROW_LEN_DEF);

    typedef enum logic {
        WAIT_W = 1'b0,
        RUN    = 1'b1
    } state_t;

    // Column counter width for a given row length; never narrower than one bit.
    function automatic int col_width(input int rowLen);
        return (rowLen < 2) ? 1 : $clog2(rowLen);
    endfunction

endpackage

// File: rtl/pu_feeder_window_shift4.sv
// Four-deep shift register holding the activation window; q1 is oldest, q4 newest.
module window_shift4
    import pu_feeder_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_q1,
    output logic [DW-1:0] o_q2,
    output logic [DW-1:0] o_q3,
    output logic [DW-1:0] o_q4
);

    logic [DW-1:0] r_q1;
    logic [DW-1:0] r_q2;
    logic [DW-1:0] r_q3;
    logic [DW-1:0] r_q4;

    // Synchronous clear wins over shifting; each shift drops the oldest tap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q1 <= '0;
            r_q2 <= '0;
            r_q3 <= '0;
            r_q4 <= '0;
        end else if (i_clr) begin
            r_q1 <= '0;
            r_q2 <= '0;
            r_q3 <= '0;
            r_q4 <= '0;
        end else if (i_en) begin
            r_q1 <= r_q2;
            r_q2 <= r_q3;
            r_q3 <= r_q4;
            r_q4 <= i_din;
        end
    end

    assign o_q1 = r_q1;
    assign o_q2 = r_q2;
    assign o_q3 = r_q3;
    assign o_q4 = r_q4;

endmodule

// File: rtl/pu_feeder.sv
// Feeder for the 4-tap processing unit: serial weight load, activation window, strobes.
module pu_feeder
    import pu_feeder_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int ROW_LEN = ROW_LEN_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          w_valid,
    input  logic [DW-1:0] w_data,
    input  logic          a_valid,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    output logic [DW-1:0] A1,
    output logic [DW-1:0] A2,
    output logic [DW-1:0] A3,
    output logic [DW-1:0] A4,
    output logic [DW-1:0] W1,
    output logic [DW-1:0] W2,
    output logic [DW-1:0] W3,
    output logic [DW-1:0] W4,
    output logic          en_reg,
    output logic          res_valid,
    output logic          row_done
);

    localparam int            CW       = col_width(ROW_LEN);
    localparam logic [CW-1:0] LAST_COL = CW'(ROW_LEN - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [1:0]    r_w_cnt;
    logic [CW-1:0] r_col;
    logic [DW-1:0] r_w1;
    logic [DW-1:0] r_w2;
    logic [DW-1:0] r_w3;
    logic [DW-1:0] r_w4;
    logic          r_en_reg;
    logic          r_row_done;
    logic          r_res_valid;
    logic          w_a_ready;
    logic          w_accept;
    logic          w_w_load;
    logic          w_win_valid;
    logic          w_row_last;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WAIT_W;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: clear always returns to weight load; the fourth beat starts streaming.
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = WAIT_W;
        end else begin
            case (r_state)
                WAIT_W:  if (w_valid && r_w_cnt == 2'd3) w_next_state = RUN;
                RUN:     w_next_state = RUN;
                default: w_next_state = WAIT_W;
            endcase
        end
    end

    // Activations are only taken while streaming and never in a clearing cycle.
    always_comb begin
        w_a_ready = 1'b0;
        if (r_state == RUN && !clear) begin
            w_a_ready = 1'b1;
        end
    end

    assign w_accept    = a_valid & w_a_ready;
    assign w_w_load    = (r_state == WAIT_W) & w_valid & ~clear;
    assign w_win_valid = (r_col >= CW'(3));
    assign w_row_last  = (r_col == LAST_COL);

    // Weight beats fill W1..W4 in order; the counter wraps back to 0 after W4.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w_cnt <= '0;
            r_w1    <= '0;
            r_w2    <= '0;
            r_w3    <= '0;
            r_w4    <= '0;
        end else if (clear) begin
            r_w_cnt <= '0;
            r_w1    <= '0;
            r_w2    <= '0;
            r_w3    <= '0;
            r_w4    <= '0;
        end else if (w_w_load) begin
            case (r_w_cnt)
                2'd0: r_w1 <= w_data;
                2'd1: r_w2 <= w_data;
                2'd2: r_w3 <= w_data;
                2'd3: r_w4 <= w_data;
                default: r_w1 <= r_w1;
            endcase
            r_w_cnt <= r_w_cnt + 2'd1;
        end
    end

    // Column position within the current row, advanced by each accepted activation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
        end else if (clear) begin
            r_col <= '0;
        end else if (w_accept) begin
            r_col <= w_row_last ? '0 : r_col + CW'(1);
        end
    end

    // Window strobes: a window is complete once three earlier taps of this row exist.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en_reg    <= 1'b0;
            r_row_done  <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_en_reg    <= w_accept & w_win_valid;
            r_row_done  <= w_accept & w_row_last;
            r_res_valid <= r_en_reg;
        end
    end

    window_shift4 #(
        .DW(DW)
    ) u_window (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_clr   (clear),
        .i_en    (w_accept),
        .i_din   (a_data),
        .o_q1    (A1),
        .o_q2    (A2),
        .o_q3    (A3),
        .o_q4    (A4)
    );

    assign a_ready   = w_a_ready;
    assign W1        = r_w1;
    assign W2        = r_w2;
    assign W3        = r_w3;
    assign W4        = r_w4;
    assign en_reg    = r_en_reg;
    assign res_valid = r_res_valid;
    assign row_done  = r_row_done;

endmodule

// File: tb/tb_pu_feeder.sv
// Self-checking bench for pu_feeder: a 16-column instance checked against a
// scoreboard model, plus a 4-column instance sharing the same stimulus.
module tb_pu_feeder;

    localparam int DW = 5;
    localparam int RL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          w_valid = 1'b0;
    logic          a_valid = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic [DW-1:0] a_data = '0;

    logic          a_ready, en_reg, res_valid, row_done;
    logic [DW-1:0] A1, A2, A3, A4, W1, W2, W3, W4;
    logic          a_ready4, en_reg4, res_valid4, row_done4;
    logic [DW-1:0] A14, A24, A34, A44, W14, W24, W34, W44;

    int nVec = 0;
    int nErr = 0;

    pu_feeder #(.DW(DW), .ROW_LEN(RL)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .w_valid(w_valid), .w_data(w_data),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .A1(A1), .A2(A2), .A3(A3), .A4(A4),
        .W1(W1), .W2(W2), .W3(W3), .W4(W4),
        .en_reg(en_reg), .res_valid(res_valid), .row_done(row_done)
    );

    pu_feeder #(.DW(DW), .ROW_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .clear(clear),
        .w_valid(w_valid), .w_data(w_data),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready4),
        .A1(A14), .A2(A24), .A3(A34), .A4(A44),
        .W1(W14), .W2(W24), .W3(W34), .W4(W44),
        .en_reg(en_reg4), .res_valid(res_valid4), .row_done(row_done4)
    );

    always #5 clk = ~clk;

    // Reference model of the 16-column instance; expected windows go to the scoreboard.
    typedef struct packed {
        logic [4*DW-1:0] win;
        logic            last;
    } exp_t;

    exp_t          expQ[$];
    logic          mRun = 1'b0;
    logic          mEn  = 1'b0;
    logic          mRes = 1'b0;
    int            mWcnt = 0;
    int            mCol  = 0;
    logic [DW-1:0] mWin[4];

    always @(posedge clk or negedge rst) begin
        exp_t e;
        if (!rst) begin
            mRun = 1'b0; mEn = 1'b0; mRes = 1'b0; mWcnt = 0; mCol = 0;
            for (int k = 0; k < 4; k++) mWin[k] = '0;
            expQ.delete();
        end else begin
            mRes = mEn;
            mEn  = 1'b0;
            if (clear) begin
                mRun = 1'b0; mWcnt = 0; mCol = 0;
                for (int k = 0; k < 4; k++) mWin[k] = '0;
                expQ.delete();
            end else if (!mRun) begin
                if (w_valid) begin
                    if (mWcnt == 3) begin
                        mRun = 1'b1; mWcnt = 0;
                    end else begin
                        mWcnt++;
                    end
                end
            end else if (a_valid) begin
                mWin[0] = mWin[1]; mWin[1] = mWin[2]; mWin[2] = mWin[3]; mWin[3] = a_data;
                if (mCol >= 3) begin
                    mEn = 1'b1;
                    e.win  = {mWin[0], mWin[1], mWin[2], mWin[3]};
                    e.last = (mCol == RL - 1);
                    expQ.push_back(e);
                end
                mCol = (mCol == RL - 1) ? 0 : mCol + 1;
            end
        end
    end

    // Scoreboard: strobes compared every cycle, windows popped whenever one is due.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            nVec++;
            if (en_reg !== mEn) begin
                nErr++;
                $display("[TB] FAIL en_reg: got %b expected %b at %0t", en_reg, mEn, $time);
            end
            nVec++;
            if (res_valid !== mRes) begin
                nErr++;
                $display("[TB] FAIL res_valid: got %b expected %b at %0t", res_valid, mRes, $time);
            end
            if (mEn) begin
                nVec++;
                if (expQ.size() == 0) begin
                    nErr++;
                    $display("[TB] FAIL scoreboard: window due but queue empty at %0t", $time);
                end else begin
                    e = expQ.pop_front();
                    if ({A1, A2, A3, A4, row_done} !== {e.win, e.last}) begin
                        nErr++;
                        $display("[TB] FAIL window: got %0d,%0d,%0d,%0d rd=%b expected %h rd=%b at %0t",
                                 A1, A2, A3, A4, row_done, e.win, e.last, $time);
                    end
                end
            end
        end
    end

    function automatic logic hasTap(input logic [4*DW-1:0] win, input logic [DW-1:0] v);
        return (win[4*DW-1:3*DW] == v) || (win[3*DW-1:2*DW] == v) ||
               (win[2*DW-1:DW] == v) || (win[DW-1:0] == v);
    endfunction

    task automatic reset_dut();
        rst = 1'b0; clear = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
        w_data = '0; a_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load_weights(input logic [DW-1:0] v1, input logic [DW-1:0] v2,
                                input logic [DW-1:0] v3, input logic [DW-1:0] v4);
        w_valid = 1'b1;
        w_data = v1; @(negedge clk);
        w_data = v2; @(negedge clk);
        w_data = v3; @(negedge clk);
        w_data = v4; @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        #1;
        nVec++;
        if ({a_ready, en_reg, res_valid, row_done, A1, A2, A3, A4, W1, W2, W3, W4} !== '0) begin
            nErr++;
            $display("[TB] FAIL reset_state16: got ready=%b en=%b rv=%b rd=%b A=%0d,%0d,%0d,%0d W=%0d,%0d,%0d,%0d required all 0",
                     a_ready, en_reg, res_valid, row_done, A1, A2, A3, A4, W1, W2, W3, W4);
        end
        nVec++;
        if ({a_ready4, en_reg4, res_valid4, row_done4, A14, A24, A34, A44, W14, W24, W34, W44} !== '0) begin
            nErr++;
            $display("[TB] FAIL reset_state4: some output nonzero, required all 0");
        end
    endtask

    task automatic test_basic_row();
        int nEn = 0, nRd = 0, rdAt = 0;
        logic [4*DW-1:0] firstWin = '0, lastWin = '0;
        reset_dut();
        load_weights(5'd1, 5'd2, 5'd3, 5'd4);
        #1;
        nVec++;
        if ({W1, W2, W3, W4} !== {5'd1, 5'd2, 5'd3, 5'd4}) begin
            nErr++;
            $display("[TB] FAIL basic_weights: got %0d,%0d,%0d,%0d required 1,2,3,4", W1, W2, W3, W4);
        end
        nVec++;
        if (a_ready !== 1'b1) begin
            nErr++;
            $display("[TB] FAIL basic_ready_after_load: got %b required 1", a_ready);
        end
        for (int i = 0; i < RL; i++) begin
            a_valid = 1'b1;
            a_data  = DW'(i + 1);
            @(negedge clk);
            if (en_reg) begin
                nEn++;
                if (nEn == 1) firstWin = {A1, A2, A3, A4};
                lastWin = {A1, A2, A3, A4};
                if (row_done) rdAt = nEn;
            end
            if (row_done) nRd++;
        end
        a_valid = 1'b0;
        @(negedge clk);
        nVec++;
        if (nEn != 13 || nRd != 1 || rdAt != 13) begin
            nErr++;
            $display("[TB] FAIL basic_counts: got en=%0d rd=%0d rdAt=%0d required 13,1,13", nEn, nRd, rdAt);
        end
        nVec++;
        if (firstWin !== {5'd1, 5'd2, 5'd3, 5'd4}) begin
            nErr++;
            $display("[TB] FAIL basic_first_window: got %h required 1,2,3,4", firstWin);
        end
        nVec++;
        if (lastWin !== {5'd13, 5'd14, 5'd15, 5'd16}) begin
            nErr++;
            $display("[TB] FAIL basic_last_window: got %h required 13,14,15,16", lastWin);
        end
    endtask

    // Continues from the end of the basic row, so the column counter starts at 0.
    // Values run 1..32; in 5 bits the final activation 32 wraps to 0.
    task automatic test_two_rows();
        int nEn = 0, nRd = 0, mixed = 0;
        logic [4*DW-1:0] win, row2First = '0;
        for (int i = 0; i < 4 * RL; i++) begin
            if (i % 2 == 0) begin
                a_valid = 1'b1;
                a_data  = DW'(i / 2 + 1);
            end else begin
                a_valid = 1'b0;
            end
            @(negedge clk);
            if (en_reg) begin
                nEn++;
                win = {A1, A2, A3, A4};
                if (row_done) nRd++;
                if (hasTap(win, 5'd16) && hasTap(win, 5'd17)) mixed++;
                if (nEn == 14) row2First = win;
            end
        end
        a_valid = 1'b0;
        @(negedge clk);
        nVec++;
        if (nEn != 26 || nRd != 2) begin
            nErr++;
            $display("[TB] FAIL two_rows_counts: got en=%0d rd=%0d required 26,2", nEn, nRd);
        end
        nVec++;
        if (mixed != 0) begin
            nErr++;
            $display("[TB] FAIL two_rows_straddle: got %0d mixed windows required 0", mixed);
        end
        nVec++;
        if (row2First !== {5'd17, 5'd18, 5'd19, 5'd20}) begin
            nErr++;
            $display("[TB] FAIL two_rows_row2_first: got %h required 17,18,19,20", row2First);
        end
    endtask

    task automatic test_gated_accept();
        int enSeen = 0;
        reset_dut();
        a_valid = 1'b1;
        a_data  = 5'd9;
        for (int k = 0; k < 4; k++) begin
            w_valid = 1'b1;
            w_data  = DW'(k + 5);
            #1;
            nVec++;
            if (a_ready !== 1'b0) begin
                nErr++;
                $display("[TB] FAIL gated_ready_beat%0d: got %b required 0", k, a_ready);
            end
            @(negedge clk);
            if (en_reg) enSeen++;
        end
        w_valid = 1'b0;
        a_valid = 1'b0;
        #1;
        nVec++;
        if (a_ready !== 1'b1 || enSeen != 0) begin
            nErr++;
            $display("[TB] FAIL gated_after_load: got ready=%b en_pulses=%0d required 1,0", a_ready, enSeen);
        end
        w_valid = 1'b1;
        w_data  = 5'd31;
        repeat (2) @(negedge clk);
        w_valid = 1'b0;
        #1;
        nVec++;
        if ({W1, W2, W3, W4} !== {5'd5, 5'd6, 5'd7, 5'd8}) begin
            nErr++;
            $display("[TB] FAIL gated_w_in_run: got %0d,%0d,%0d,%0d required 5,6,7,8", W1, W2, W3, W4);
        end
    endtask

    task automatic test_clear();
        reset_dut();
        load_weights(5'd3, 5'd5, 5'd7, 5'd9);
        for (int i = 0; i < 7; i++) begin
            a_valid = 1'b1;
            a_data  = DW'(i + 1);
            @(negedge clk);
        end
        nVec++;
        if (en_reg !== 1'b1) begin
            nErr++;
            $display("[TB] FAIL clear_pre_en: got %b required 1", en_reg);
        end
        clear   = 1'b1;
        a_valid = 1'b1;
        a_data  = 5'd8;
        #1;
        nVec++;
        if (a_ready !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL clear_ready: got %b required 0", a_ready);
        end
        @(negedge clk);
        nVec++;
        if ({en_reg, res_valid, row_done} !== 3'b010) begin
            nErr++;
            $display("[TB] FAIL clear_strobes: got en=%b rv=%b rd=%b required 0,1,0", en_reg, res_valid, row_done);
        end
        nVec++;
        if ({A1, A2, A3, A4, W1, W2, W3, W4} !== '0) begin
            nErr++;
            $display("[TB] FAIL clear_regs: got A=%0d,%0d,%0d,%0d W=%0d,%0d,%0d,%0d required 0",
                     A1, A2, A3, A4, W1, W2, W3, W4);
        end
        clear   = 1'b0;
        a_valid = 1'b0;
        #1;
        nVec++;
        if (a_ready !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL clear_wait_w: got ready=%b required 0", a_ready);
        end
        @(negedge clk);
        nVec++;
        if (res_valid !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL clear_single_res: got %b required 0", res_valid);
        end
        w_valid = 1'b1;
        w_data  = 5'd11;
        @(negedge clk);
        w_valid = 1'b0;
        #1;
        nVec++;
        if ({W1, W2, W3, W4} !== {5'd11, 5'd0, 5'd0, 5'd0}) begin
            nErr++;
            $display("[TB] FAIL clear_reload_w1: got %0d,%0d,%0d,%0d required 11,0,0,0", W1, W2, W3, W4);
        end
    endtask

    task automatic test_async_reset();
        logic preEn;
        reset_dut();
        load_weights(5'd2, 5'd2, 5'd2, 5'd2);
        for (int i = 0; i < 5; i++) begin
            a_valid = 1'b1;
            a_data  = DW'(i + 1);
            @(negedge clk);
        end
        a_data = 5'd6;
        preEn  = en_reg;
        #2;
        rst = 1'b0;
        #1;
        nVec++;
        if (preEn !== 1'b1) begin
            nErr++;
            $display("[TB] FAIL async_pre_en: got %b required 1", preEn);
        end
        nVec++;
        if ({a_ready, en_reg, res_valid, row_done, A1, A2, A3, A4, W1, W2, W3, W4} !== '0) begin
            nErr++;
            $display("[TB] FAIL async_outputs: got ready=%b en=%b rv=%b A4=%0d W1=%0d required all 0",
                     a_ready, en_reg, res_valid, A4, W1);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        nVec++;
        if (a_ready !== 1'b0) begin
            nErr++;
            $display("[TB] FAIL async_needs_weights: got ready=%b required 0", a_ready);
        end
        @(negedge clk);
        nVec++;
        if ({en_reg, A1, A2, A3, A4} !== '0) begin
            nErr++;
            $display("[TB] FAIL async_no_accept: got en=%b A4=%0d required 0", en_reg, A4);
        end
        a_valid = 1'b0;
        load_weights(5'd4, 5'd3, 5'd2, 5'd1);
        #1;
        nVec++;
        if (a_ready !== 1'b1 || {W1, W2, W3, W4} !== {5'd4, 5'd3, 5'd2, 5'd1}) begin
            nErr++;
            $display("[TB] FAIL async_reload: got ready=%b W=%0d,%0d,%0d,%0d required 1 and 4,3,2,1",
                     a_ready, W1, W2, W3, W4);
        end
    endtask

    task automatic test_min_row();
        int nEn = 0, nRd = 0, apart = 0;
        logic [4*DW-1:0] win1 = '0, win2 = '0;
        reset_dut();
        load_weights(5'd1, 5'd1, 5'd1, 5'd1);
        for (int i = 0; i < 8; i++) begin
            a_valid = 1'b1;
            a_data  = DW'(i + 1);
            @(negedge clk);
            if (en_reg4 !== row_done4) apart++;
            if (en_reg4) begin
                nEn++;
                if (nEn == 1) win1 = {A14, A24, A34, A44};
                if (nEn == 2) win2 = {A14, A24, A34, A44};
            end
            if (row_done4) nRd++;
        end
        a_valid = 1'b0;
        @(negedge clk);
        nVec++;
        if (nEn != 2 || nRd != 2 || apart != 0) begin
            nErr++;
            $display("[TB] FAIL min_row_counts: got en=%0d rd=%0d apart=%0d required 2,2,0", nEn, nRd, apart);
        end
        nVec++;
        if (win1 !== {5'd1, 5'd2, 5'd3, 5'd4} || win2 !== {5'd5, 5'd6, 5'd7, 5'd8}) begin
            nErr++;
            $display("[TB] FAIL min_row_windows: got %h / %h required 1,2,3,4 / 5,6,7,8", win1, win2);
        end
    endtask

    initial begin
        test_reset();
        test_basic_row();
        test_two_rows();
        test_gated_accept();
        test_clear();
        test_async_reset();
        test_min_row();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
